// File: rtl/bit_deser_pkg.sv
// Shared types and sizing helpers for the bit_deser serial-to-parallel deserializer.
package bit_deser_pkg;

    typedef enum logic {EMPTY, FULL} hold_state_t;

    localparam int WORDS_CNT_W = 16;

    // Bit-count width; a 2-bit word still needs a 1-bit counter.
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/bit_deser_if.sv
// Serial-in / word-out handshake bundle for bit_deser.
interface bit_deser_if #(
    parameter int unsigned WIDTH = 8
);
    import bit_deser_pkg::*;

    logic                   bit_in;
    logic                   bit_vld;
    logic                   flush;
    logic [WIDTH-1:0]       word_data;
    logic                   word_vld;
    logic                   word_rdy;
    logic                   ovf;
    logic                   ovf_clr;
    logic [WORDS_CNT_W-1:0] words_out;

    // Environment side: drives the serial stream and consumes words.
    modport master (
        output bit_in, bit_vld, flush, word_rdy, ovf_clr,
        input  word_data, word_vld, ovf, words_out
    );

    // Deserializer side.
    modport slave (
        input  bit_in, bit_vld, flush, word_rdy, ovf_clr,
        output word_data, word_vld, ovf, words_out
    );

endinterface

// File: rtl/bit_shreg.sv
// WIDTH-bit shift register; MSB_FIRST selects which end new bits enter from.
module bit_shreg #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             shift_en,
    input  logic             din,
    output logic [WIDTH-1:0] next_word
);

    logic [WIDTH-1:0] q;

    // next_word is the value after this edge's shift, so the top can capture
    // a completed word on the same edge the last bit arrives.
    generate
        if (MSB_FIRST) begin : g_msb
            assign next_word = {q[WIDTH-2:0], din};
        end else begin : g_lsb
            assign next_word = {din, q[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (shift_en) begin
            q <= next_word;
        end
    end

endmodule

// File: rtl/bit_deser.sv
// Deserializer top: bit counting, holding-register FSM, overflow flag and word counter.
module bit_deser
    import bit_deser_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    bit_deser_if.slave  bus
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    hold_state_t            state;
    hold_state_t            state_next;
    logic [CNT_W-1:0]       bit_cnt;
    logic [WIDTH-1:0]       next_word;
    logic [WIDTH-1:0]       word_q;
    logic                   ovf_q;
    logic [WORDS_CNT_W-1:0] words_q;
    logic                   accept;
    logic                   complete;
    logic                   drain;
    logic                   load;
    logic                   drop;

    // Flush wins over bit_vld, so a bit arriving with flush is discarded.
    assign accept   = bus.bit_vld && !bus.flush;
    assign complete = accept && (bit_cnt == LAST_BIT);
    assign drain    = (state == FULL) && bus.word_rdy;

    bit_shreg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shreg (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (bus.flush),
        .shift_en  (accept),
        .din       (bus.bit_in),
        .next_word (next_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt <= '0;
        end else if (bus.flush) begin
            bit_cnt <= '0;
        end else if (accept) begin
            bit_cnt <= complete ? '0 : bit_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // A completed word loads if the holder is empty or emptying this edge;
    // otherwise it is dropped and the held word is left intact.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        drop       = 1'b0;
        case (state)
            EMPTY: begin
                if (complete) begin
                    load       = 1'b1;
                    state_next = FULL;
                end
            end
            FULL: begin
                if (complete && drain) begin
                    load = 1'b1;
                end else if (complete) begin
                    drop = 1'b1;
                end else if (drain) begin
                    state_next = EMPTY;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q  <= '0;
            ovf_q   <= 1'b0;
            words_q <= '0;
        end else begin
            if (load) begin
                word_q <= next_word;
            end
            if (drop) begin
                ovf_q <= 1'b1;
            end else if (bus.ovf_clr) begin
                ovf_q <= 1'b0;
            end
            if (drain) begin
                words_q <= words_q + 1'b1;
            end
        end
    end

    assign bus.word_data = word_q;
    assign bus.word_vld  = (state == FULL);
    assign bus.ovf       = ovf_q;
    assign bus.words_out = words_q;

endmodule

// File: tb/tb_bit_deser.sv
// Directed bench for bit_deser: MSB- and LSB-first instances fed the same stream, checked against a queue-based model.
module tb_bit_deser;
    import bit_deser_pkg::*;

    localparam int W = 8;

    logic clk      = 1'b0;
    logic rst_n    = 1'b0;
    logic bit_in   = 1'b0;
    logic bit_vld  = 1'b0;
    logic flush    = 1'b0;
    logic ovf_clr  = 1'b0;
    logic rdy      = 1'b0;

    int checks = 0;
    int errors = 0;

    bit_deser_if #(.WIDTH(W)) bus_m ();
    bit_deser_if #(.WIDTH(W)) bus_l ();

    assign bus_m.bit_in   = bit_in;
    assign bus_m.bit_vld  = bit_vld;
    assign bus_m.flush    = flush;
    assign bus_m.word_rdy = rdy;
    assign bus_m.ovf_clr  = ovf_clr;
    assign bus_l.bit_in   = bit_in;
    assign bus_l.bit_vld  = bit_vld;
    assign bus_l.flush    = flush;
    assign bus_l.word_rdy = rdy;
    assign bus_l.ovf_clr  = ovf_clr;

    bit_deser #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_m)
    );

    bit_deser #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_l)
    );

    always #5 clk = ~clk;

    // Model: pending bits in a queue, one holding slot shared by both orderings.
    int          bits[$];
    bit          m_vld = 1'b0;
    logic [7:0]  m_msb = '0;
    logic [7:0]  m_lsb = '0;
    bit          m_ovf = 1'b0;
    logic [15:0] m_cnt = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bits.delete();
            m_vld = 1'b0;
            m_msb = '0;
            m_lsb = '0;
            m_ovf = 1'b0;
            m_cnt = '0;
        end else begin
            automatic bit          done = 1'b0;
            automatic int unsigned wm   = 0;
            automatic int unsigned wl   = 0;
            if (flush) begin
                bits.delete();
            end else if (bit_vld) begin
                bits.push_back(int'(bit_in));
                if (bits.size() == W) begin
                    for (int i = 0; i < W; i++) begin
                        wm = wm * 2 + bits[i];
                        wl = wl + (bits[i] << i);
                    end
                    done = 1'b1;
                    bits.delete();
                end
            end
            if (m_vld && rdy) begin
                m_cnt = m_cnt + 16'd1;
                m_vld = 1'b0;
            end
            if (done && m_vld) begin
                m_ovf = 1'b1;
            end else begin
                if (done) begin
                    m_vld = 1'b1;
                    m_msb = wm[7:0];
                    m_lsb = wl[7:0];
                end
                if (ovf_clr) m_ovf = 1'b0;
            end
        end
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        check_output("msb.word_vld",  32'(bus_m.word_vld),  32'(m_vld));
        check_output("lsb.word_vld",  32'(bus_l.word_vld),  32'(m_vld));
        check_output("msb.ovf",       32'(bus_m.ovf),       32'(m_ovf));
        check_output("lsb.ovf",       32'(bus_l.ovf),       32'(m_ovf));
        check_output("msb.words_out", 32'(bus_m.words_out), 32'(m_cnt));
        check_output("lsb.words_out", 32'(bus_l.words_out), 32'(m_cnt));
        if (m_vld) begin
            check_output("msb.word_data", 32'(bus_m.word_data), 32'(m_msb));
            check_output("lsb.word_data", 32'(bus_l.word_data), 32'(m_lsb));
        end
    end

    task automatic apply_stimulus(input logic b, input logic v, input logic f, input logic c);
        @(posedge clk);
        #1;
        bit_in  = b;
        bit_vld = v;
        flush   = f;
        ovf_clr = c;
    endtask

    task automatic idle();
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Sends val[7] first; gap idle cycles between bits; clr_last pulses ovf_clr with the final bit.
    task automatic send_byte(input logic [7:0] val, input int gap, input bit clr_last);
        for (int i = 7; i >= 0; i--) begin
            apply_stimulus(val[i], 1'b1, 1'b0, clr_last && (i == 0));
            if (i != 0) repeat (gap) idle();
        end
    endtask

    initial begin
        repeat (3) idle();
        check_output("rst.word_vld",  32'(bus_m.word_vld),  32'h0);
        check_output("rst.word_data", 32'(bus_m.word_data), 32'h0);
        check_output("rst.ovf",       32'(bus_m.ovf),       32'h0);
        check_output("rst.words_out", 32'(bus_m.words_out), 32'h0);
        rst_n = 1'b1;
        rdy   = 1'b1;

        send_byte(8'hA5, 0, 1'b0);
        idle();
        check_output("a5.msb_data", 32'(bus_m.word_data), 32'hA5);
        check_output("a5.lsb_data", 32'(bus_l.word_data), 32'hA5);
        check_output("a5.vld",      32'(bus_m.word_vld),  32'h1);
        idle();
        check_output("a5.words_out", 32'(bus_m.words_out), 32'h1);
        check_output("a5.vld_drop",  32'(bus_m.word_vld),  32'h0);

        send_byte(8'hC0, 0, 1'b0);
        idle();
        check_output("c0.msb_data", 32'(bus_m.word_data), 32'hC0);
        check_output("03.lsb_data", 32'(bus_l.word_data), 32'h03);
        idle();

        send_byte(8'hA5, 2, 1'b0);
        idle();
        check_output("gap.msb_data", 32'(bus_m.word_data), 32'hA5);
        idle();
        check_output("gap.words_out", 32'(bus_m.words_out), 32'h3);

        rdy = 1'b0;
        send_byte(8'h11, 0, 1'b0);
        idle();
        check_output("hold.data", 32'(bus_m.word_data), 32'h11);
        send_byte(8'h22, 0, 1'b1);
        idle();
        check_output("ovf.set",       32'(bus_m.ovf),       32'h1);
        check_output("ovf.kept_data", 32'(bus_m.word_data), 32'h11);
        check_output("ovf.words_out", 32'(bus_m.words_out), 32'h3);
        rdy = 1'b1;
        idle();
        check_output("drain.vld",       32'(bus_m.word_vld),  32'h0);
        check_output("drain.words_out", 32'(bus_m.words_out), 32'h4);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1);
        idle();
        check_output("ovf.cleared", 32'(bus_m.ovf), 32'h0);

        repeat (4) apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0);
        send_byte(8'h5A, 0, 1'b0);
        idle();
        check_output("flush.data", 32'(bus_m.word_data), 32'h5A);
        idle();
        repeat (3) apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0);
        apply_stimulus(1'b1, 1'b1, 1'b1, 1'b0);
        send_byte(8'h3C, 0, 1'b0);
        idle();
        check_output("flush_vld.data", 32'(bus_m.word_data), 32'h3C);
        idle();
        check_output("flush.words_out", 32'(bus_m.words_out), 32'h6);

        rdy = 1'b0;
        send_byte(8'h77, 0, 1'b0);
        apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0);
        apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0);
        apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0);
        idle();
        rst_n = 1'b0;
        #1;
        check_output("mid_rst.word_vld",  32'(bus_m.word_vld),  32'h0);
        check_output("mid_rst.word_data", 32'(bus_m.word_data), 32'h0);
        check_output("mid_rst.words_out", 32'(bus_m.words_out), 32'h0);
        idle();
        rst_n = 1'b1;
        rdy   = 1'b1;
        send_byte(8'hFF, 0, 1'b0);
        idle();
        check_output("ff.msb_data", 32'(bus_m.word_data), 32'hFF);
        check_output("ff.lsb_data", 32'(bus_l.word_data), 32'hFF);
        idle();
        check_output("ff.words_out", 32'(bus_m.words_out), 32'h1);

        repeat (2) idle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bit_deser.md
# bit_deser

Serial-to-parallel deserializer that sits directly downstream of the `dff` capture stage. It samples the registered one-bit stream under a bit-valid qualifier and packs `WIDTH` consecutive bits into a word. Each word goes to the consumer over a valid/ready handshake with a single output holding register. It flags dropped words with a sticky overflow and keeps a running count of delivered words for scoreboarding.

## Interface
- `WIDTH`, 8: bits per output word; 2..32.
- `MSB_FIRST`, 1: 1 = first received bit lands in `word_data[WIDTH-1]`; 0 = first bit lands in `word_data[0]`.
- `clk` input 1: single clock; all state changes on posedge.
- `rst` input 1: reset, asynchronous assert, active-low; release is synchronous to `clk` upstream.
- `bit_in` input 1: serial data from the capture flip-flop output.
- `bit_vld` input 1: `bit_in` is sampled on this edge.
- `flush` input 1: discard the partial word and restart alignment.
- `word_data` output WIDTH: assembled word; stable while `word_vld`=1.
- `word_vld` output 1: holding register occupied.
- `word_rdy` input 1: consumer accepts when `word_vld`&&`word_rdy`.
- `ovf` output 1: sticky; a completed word was dropped.
- `ovf_clr` input 1: clears `ovf`.
- `words_out` output 16: count of accepted words; wraps 0xFFFF->0.

## Operation
- Reset (`rst`=0) values: shift register 0, bit count 0, `word_data`=0, `word_vld`=0, `ovf`=0, `words_out`=0.
- Reset taken mid-word discards the partial word and any held word.
- Accumulate: on `bit_vld`=1, shift `bit_in` into the shift register in the order set by `MSB_FIRST`, then increment the bit count.
- Completion: the bit with count = WIDTH-1 completes a word. The count wraps to 0 on the same edge.
- Hand-off to the holding register at completion:
  - Register empty, or being drained this cycle (`word_vld`&&`word_rdy`): load the completed word; `word_vld`=1 next cycle.
  - Register full and not draining: drop the completed word, set `ovf`, leave the held word untouched.
- Drain: `word_vld`&&`word_rdy` with no simultaneous load clears `word_vld`. Every accepted word increments `words_out`.
- Flush: zero the bit count and shift register; `bit_vld` on the same edge is ignored. The holding register, `ovf` and `words_out` are unaffected.
- `ovf_clr` and a new overflow on the same edge: the set wins, so `ovf` stays 1.
- FSM states:
  - `EMPTY`: `word_vld`=0.
  - `FULL`: `word_vld`=1.
- FSM transitions:
  - EMPTY->FULL on completion.
  - FULL->EMPTY on drain without completion.
  - FULL->FULL on drain with completion, or on stall without completion.
  - FULL with completion and no drain is the overflow case; state stays FULL.

## Timing
- Latency: the WIDTH-th valid bit is sampled at edge N; `word_vld`=1 and `word_data` are valid after edge N.
- Throughput: one word per WIDTH valid bits, no bubbles when `word_rdy` is held high.
- `word_data` and `word_vld` are registered outputs with no combinational path from inputs.
- `word_rdy` may be high while `word_vld`=0; this has no effect.
- `word_vld` never drops without acceptance. The only exceptions are reset and back-to-back replacement on a drain edge.

## Structure
- `bit_deser_pkg` holds:
  - `typedef enum logic {EMPTY, FULL} hold_state_t`
  - `localparam CNT_W = $clog2(WIDTH)` helper function
  - `WORDS_CNT_W = 16`
- One sub-module, `bit_shreg`: WIDTH-bit shift register with direction parameter and synchronous clear.
- Count, FSM and flags live in the top level.

## Test plan
- Reset, then 8 valid bits 1,0,1,0,0,1,0,1 with `MSB_FIRST`=1 and `word_rdy`=1 -> `word_data`=0xA5 one cycle after bit 8; `words_out`=1.
- Same bits with `MSB_FIRST`=0 -> `word_data`=0xA5 again (palindrome check). Then bits 1,1,0,0,0,0,0,0 -> 0x03.
- `bit_vld` gaps (one valid bit every third cycle) -> identical word 0xA5; no extra `word_vld` pulses.
- `word_rdy`=0 while 0x11 is held, then 8 bits of 0x22 -> 0x22 dropped, `ovf`=1, `word_data` still 0x11. Raise `word_rdy` -> 0x11 accepted, `word_vld`=0, `words_out`+1. Pulse `ovf_clr` -> `ovf`=0.
- 4 bits sent, then `flush`, then 8 bits of 0x5A -> output 0x5A only. Flush asserted together with `bit_vld` -> that bit ignored.
- Assert `rst` after 5 bits with a word held -> all outputs 0 immediately. After release, 8 bits of 0xFF -> 0xFF with `words_out`=1.
